msi_bus_request_sequencer: RTL and testbench

Per-cache sequential stage directly downstream of the MSI CPU-request controller. Captures one resolved CPU access (next state, bus code, write-back flag) and performs the required shared-bus traffic in order: victim write-back first, then the coherence transaction. After the bus work completes, it commits the new line state to the cache tag array.

---
 rtl/msi_pkg.sv | 31 +++
 rtl/msi_bus_watchdog.sv | 35 +++
 rtl/msi_bus_request_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_msi_bus_request_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// Shared MSI definitions: line states, bus command codes and the sequencer FSM encoding.
package msi_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    MODIFIED = 2'b01,
    SHARED   = 2'b10,
    ERROR    = 2'b11
  } line_state_e;

  localparam logic [1:0] BUS_INVALIDATE = 2'b00;
  localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
  localparam logic [1:0] BUS_READ_MISS  = 2'b10;
  localparam logic [1:0] BUS_WRITE_BACK = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbXfer,
    StReq,
    StXfer,
    StCommit,
    StErrDrain
  } seq_state_e;

  // A miss always needs the bus; a write hit on a SHARED line needs an invalidate.
  function automatic logic bus_needed(logic hit, logic [1:0] st_in, logic [1:0] st_next);
    return !hit || (st_in == SHARED && st_next == MODIFIED);
  endfunction

endpackage

// File: rtl/msi_bus_watchdog.sv
// Loadable down-counter; expire_o pulses when a decrement would reach zero.
module msi_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  localparam int unsigned CntW = 16;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(TIMEOUT_CYC);
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire_o = dec_i && !load_i && (cnt_q == CntW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msi_bus_request_sequencer.sv
// Sequences victim write-back and coherence bus traffic for one resolved CPU access,
// then commits the new line state to the tag array.
module msi_bus_request_sequencer
  import msi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BLOCK_W     = 128,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_hit,
  input  logic [1:0]         state_in,
  input  logic [1:0]         state_next,
  input  logic [1:0]         bus_next,
  input  logic               write_back_block_next,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [BLOCK_W-1:0] wb_data,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic [1:0]         bus_cmd,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [BLOCK_W-1:0] bus_data,
  input  logic               bus_done,
  output logic               commit_valid,
  output logic [ADDR_W-1:0]  commit_addr,
  output logic [1:0]         commit_state,
  output logic               err
);

  seq_state_e state_q, state_d;

  logic [ADDR_W-1:0]  req_addr_q, req_addr_d, wb_addr_q, wb_addr_d;
  logic [BLOCK_W-1:0] wb_data_q, wb_data_d;
  logic [1:0]         state_next_q, state_next_d, bus_next_q, bus_next_d;
  logic               need_bus_q, need_bus_d;

  logic               req_ready_q, req_ready_d, bus_req_q, bus_req_d;
  logic [1:0]         bus_cmd_q, bus_cmd_d, commit_state_q, commit_state_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d, commit_addr_q, commit_addr_d;
  logic [BLOCK_W-1:0] bus_data_q, bus_data_d;
  logic               commit_valid_q, commit_valid_d, err_q, err_d;

  logic accept, req_err, timeout, wd_load, wd_dec, wd_expire;

  assign accept  = req_valid && req_ready_q;
  assign req_err = (state_next == ERROR) || (bus_next == 2'b11);
  assign wd_load = (state_q == StWbReq || state_q == StReq) && bus_gnt;
  assign wd_dec  = (state_q == StWbXfer || state_q == StXfer) && !bus_done;

  msi_bus_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (wd_load),
    .dec_i   (wd_dec),
    .expire_o(wd_expire)
  );

  always_comb begin
    req_addr_d   = req_addr_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    state_next_d = state_next_q;
    bus_next_d   = bus_next_q;
    need_bus_d   = need_bus_q;
    if (accept) begin
      req_addr_d   = req_addr;
      wb_addr_d    = wb_addr;
      wb_data_d    = wb_data;
      state_next_d = state_next;
      bus_next_d   = bus_next;
      need_bus_d   = bus_needed(req_hit, state_in, state_next);
    end
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)                                         state_d = StErrDrain;
          else if (write_back_block_next)                      state_d = StWbReq;
          else if (bus_needed(req_hit, state_in, state_next))  state_d = StReq;
          else                                                 state_d = StCommit;
        end
      end
      StWbReq:  if (bus_gnt) state_d = StWbXfer;
      StWbXfer: begin
        if (bus_done) begin
          state_d = need_bus_q ? StReq : StCommit;
        end else if (wd_expire) begin
          state_d = StCommit;
          timeout = 1'b1;
        end
      end
      StReq:    if (bus_gnt) state_d = StXfer;
      StXfer: begin
        if (bus_done) begin
          state_d = StCommit;
        end else if (wd_expire) begin
          state_d = StCommit;
          timeout = 1'b1;
        end
      end
      StCommit:   state_d = StIdle;
      StErrDrain: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    req_ready_d    = (state_d == StIdle);
    bus_req_d      = 1'b0;
    bus_cmd_d      = BUS_INVALIDATE;
    bus_addr_d     = '0;
    bus_data_d     = '0;
    commit_valid_d = 1'b0;
    commit_addr_d  = commit_addr_q;
    commit_state_d = commit_state_q;
    err_d          = err_q | timeout | (accept && req_err);
    unique case (state_d)
      StWbReq, StWbXfer: begin
        bus_req_d  = 1'b1;
        bus_cmd_d  = BUS_WRITE_BACK;
        bus_addr_d = wb_addr_d;
        bus_data_d = wb_data_d;
      end
      StReq, StXfer: begin
        bus_req_d  = 1'b1;
        bus_cmd_d  = bus_next_d;
        bus_addr_d = req_addr_d;
      end
      StCommit: begin
        commit_valid_d = 1'b1;
        commit_addr_d  = req_addr_d;
        commit_state_d = timeout ? INVALID : state_next_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_addr_q     <= '0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      state_next_q   <= 2'b00;
      bus_next_q     <= 2'b00;
      need_bus_q     <= 1'b0;
      req_ready_q    <= 1'b1;
      bus_req_q      <= 1'b0;
      bus_cmd_q      <= 2'b00;
      bus_addr_q     <= '0;
      bus_data_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
      commit_state_q <= 2'b00;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      state_next_q   <= state_next_d;
      bus_next_q     <= bus_next_d;
      need_bus_q     <= need_bus_d;
      req_ready_q    <= req_ready_d;
      bus_req_q      <= bus_req_d;
      bus_cmd_q      <= bus_cmd_d;
      bus_addr_q     <= bus_addr_d;
      bus_data_q     <= bus_data_d;
      commit_valid_q <= commit_valid_d;
      commit_addr_q  <= commit_addr_d;
      commit_state_q <= commit_state_d;
      err_q          <= err_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign bus_req      = bus_req_q;
  assign bus_cmd      = bus_cmd_q;
  assign bus_addr     = bus_addr_q;
  assign bus_data     = bus_data_q;
  assign commit_valid = commit_valid_q;
  assign commit_addr  = commit_addr_q;
  assign commit_state = commit_state_q;
  assign err          = err_q;

endmodule

// File: tb/tb_msi_bus_request_sequencer.sv
// Bench for msi_bus_request_sequencer: directed table, corner sequences and a random run
// against a transaction-level model of bus traffic, commit timing and the error flag.
module tb_msi_bus_request_sequencer;
  import msi_pkg::*;

  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_hit, wbb;
  logic [1:0]   state_in, state_next, bus_next;
  logic [31:0]  req_addr, wb_addr;
  logic [127:0] wb_data;
  logic         bus_req, bus_gnt, bus_done;
  logic [1:0]   bus_cmd, commit_state;
  logic [31:0]  bus_addr, commit_addr;
  logic [127:0] bus_data;
  logic         commit_valid, err;

  int n_chk  = 0;
  int n_pass = 0;
  logic err_sticky = 1'b0;

  msi_bus_request_sequencer #(
    .ADDR_W     (32),
    .BLOCK_W    (128),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_hit              (req_hit),
    .state_in             (state_in),
    .state_next           (state_next),
    .bus_next             (bus_next),
    .write_back_block_next(wbb),
    .req_addr             (req_addr),
    .wb_addr              (wb_addr),
    .wb_data              (wb_data),
    .bus_req              (bus_req),
    .bus_gnt              (bus_gnt),
    .bus_cmd              (bus_cmd),
    .bus_addr             (bus_addr),
    .bus_data             (bus_data),
    .bus_done             (bus_done),
    .commit_valid         (commit_valid),
    .commit_addr          (commit_addr),
    .commit_state         (commit_state),
    .err                  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         hit;
    logic [1:0]   si, sn, bn;
    logic         wb;
    logic [31:0]  ra, wa;
    logic [127:0] wd;
    int           gd, w0, w1;       // grant delay, done index of 1st/2nd transfer
    int           exp_commit;       // cycle of commit pulse after accept, -1 = none
    logic [1:0]   exp_state;
    int           exp_bus;          // cycles with bus_req high
    logic         exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction-level model: list the transfers, add up request and transfer lengths.
  function automatic vec_t model(input vec_t v, input logic sticky);
    vec_t r;
    int   t, lens, n;
    bit   to;
    bit   txs[2];
    int   ws[2];
    r = v; t = 1; n = 0; to = 0;
    ws[0] = v.w0; ws[1] = v.w1;
    r.exp_bus = 0;
    if (v.sn == 2'b11 || v.bn == 2'b11) begin
      r.exp_commit = -1; r.exp_state = 2'b00; r.exp_err = 1'b1;
      return r;
    end
    txs[0] = v.wb;
    txs[1] = !v.hit || (v.si == SHARED && v.sn == MODIFIED);
    for (int k = 0; k < 2; k++) begin
      if (txs[k] && !to) begin
        lens = (n == 0) ? v.gd + 1 : 1;
        if (ws[n] >= T) begin lens += T; to = 1; end
        else lens += ws[n] + 1;
        n++;
        r.exp_bus += lens;
        t += lens;
      end
    end
    r.exp_commit = t;
    r.exp_state  = to ? 2'b00 : v.sn;
    r.exp_err    = sticky | to;
    return r;
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge where req_ready is seen.
  task automatic run_req(input string name, input vec_t v);
    logic [1:0]   tcmd  [2];
    logic [31:0]  taddr [2];
    logic [127:0] tdata [2];
    int ntx, txi, ph, cnt, xc, nbus, ncom, mism, cyc_commit, ready_cyc;
    int w [2];
    logic [31:0] cadr;
    logic [1:0]  cst;
    ntx = 0; txi = 0; ph = 0; cnt = 0; xc = 0; nbus = 0; ncom = 0; mism = 0;
    cyc_commit = -1; ready_cyc = -1; cadr = '0; cst = '0;
    w[0] = v.w0; w[1] = v.w1;
    if (!(v.sn == 2'b11 || v.bn == 2'b11)) begin
      if (v.wb) begin
        tcmd[ntx] = BUS_WRITE_BACK; taddr[ntx] = v.wa; tdata[ntx] = v.wd; ntx++;
      end
      if (!v.hit || (v.si == SHARED && v.sn == MODIFIED)) begin
        tcmd[ntx] = v.bn; taddr[ntx] = v.ra; tdata[ntx] = '0; ntx++;
      end
    end
    req_valid = 1'b1; req_hit = v.hit; state_in = v.si; state_next = v.sn;
    bus_next = v.bn; wbb = v.wb; req_addr = v.ra; wb_addr = v.wa; wb_data = v.wd;
    for (int c = 1; c <= 60 && ready_cyc < 0; c++) begin
      @(negedge clk);
      bus_done = 1'b0;
      if (c == 1) begin
        req_valid = 1'b0; req_hit = ~v.hit; state_next = 2'($urandom);
        bus_next = 2'($urandom); wbb = ~v.wb; req_addr = $urandom; wb_addr = $urandom;
        wb_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (commit_valid) begin
        ncom++;
        if (cyc_commit < 0) begin cyc_commit = c; cadr = commit_addr; cst = commit_state; end
      end
      if (req_ready && ready_cyc < 0) ready_cyc = c;
      if (bus_req) begin
        nbus++;
        if (txi >= ntx) mism++;
        else if (bus_cmd !== tcmd[txi] || bus_addr !== taddr[txi] || bus_data !== tdata[txi])
          mism++;
      end
      // arbiter and bus responder
      if (!bus_req) begin
        bus_gnt = 1'b0; ph = 0; cnt = 0;
      end else if (ph == 0) begin
        cnt++;
        if (bus_gnt || cnt >= v.gd + 1) begin bus_gnt = 1'b1; ph = 1; xc = 0; end
      end else if (txi < 2 && xc == w[txi]) begin
        bus_done = 1'b1; txi++; ph = 0; cnt = 0;
      end else begin
        xc++;
      end
    end
    check({name, " commit_cycle"}, cyc_commit, v.exp_commit);
    check({name, " commit_count"}, ncom, (v.exp_commit >= 0) ? 1 : 0);
    if (v.exp_commit >= 0) begin
      check({name, " commit_addr"}, cadr, v.ra);
      check({name, " commit_state"}, cst, v.exp_state);
    end
    check({name, " bus_req_cycles"}, nbus, v.exp_bus);
    check({name, " bus_fields"}, mism, 0);
    check({name, " ready_cycle"}, ready_cyc, (v.exp_commit >= 0) ? v.exp_commit + 1 : 2);
    check({name, " err"}, err, v.exp_err);
  endtask

  initial begin
    vec_t v;
    int   ncom;
    logic [31:0] last_addr;
    logic [127:0] pat;
    pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rst_n = 1'b0; req_valid = 1'b0; req_hit = 1'b0; wbb = 1'b0;
    state_in = '0; state_next = '0; bus_next = '0; req_addr = '0; wb_addr = '0;
    wb_data = '0; bus_gnt = 1'b0; bus_done = 1'b0;

    //            hit si        sn        bn     wb ra            wa            wd   gd w0 w1 cmt st    bus err
    vecs[0] = '{1'b1, SHARED,   SHARED,   2'b00, 1'b0, 32'h0000_1000, 32'h0, '0,  0, 0, 0, 1,  2'b10, 0, 1'b0};
    vecs[1] = '{1'b0, INVALID,  SHARED,   2'b10, 1'b0, 32'h1234_5670, 32'h0, '0,  1, 1, 0, 5,  2'b10, 4, 1'b0};
    vecs[2] = '{1'b0, MODIFIED, MODIFIED, 2'b01, 1'b1, 32'h200, 32'h100,      pat, 0, 0, 0, 5,  2'b01, 4, 1'b0};
    vecs[3] = '{1'b1, SHARED,   MODIFIED, 2'b00, 1'b0, 32'h300, 32'h0,        '0,  0, 0, 0, 3,  2'b01, 2, 1'b0};
    vecs[4] = '{1'b1, MODIFIED, MODIFIED, 2'b00, 1'b0, 32'h400, 32'h0,        '0,  0, 0, 0, 1,  2'b01, 0, 1'b0};
    vecs[5] = '{1'b0, SHARED,   SHARED,   2'b10, 1'b1, 32'h500, 32'h580,      ~pat, 2, 1, 2, 10, 2'b10, 9, 1'b0};
    vecs[6] = '{1'b0, INVALID,  SHARED,   2'b10, 1'b0, 32'h600, 32'h0,        '0,  0, 9, 0, 6,  2'b00, 5, 1'b1};
    vecs[7] = '{1'b0, MODIFIED, MODIFIED, 2'b01, 1'b1, 32'h700, 32'h780,      pat, 2, 5, 0, 8,  2'b00, 7, 1'b1};
    vecs[8] = '{1'b0, INVALID,  ERROR,    2'b10, 1'b0, 32'h800, 32'h0,        '0,  0, 0, 0, -1, 2'b00, 0, 1'b1};
    vecs[9] = '{1'b0, MODIFIED, SHARED,   2'b11, 1'b1, 32'h900, 32'h980,      pat, 0, 0, 0, -1, 2'b00, 0, 1'b1};

    @(negedge clk);
    check("rst req_ready", req_ready, 1'b1);
    check("rst bus_req", bus_req, 1'b0);
    check("rst bus_cmd", bus_cmd, 2'b00);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst bus_data", bus_data, 128'h0);
    check("rst commit_valid", commit_valid, 1'b0);
    check("rst commit_addr", commit_addr, 32'h0);
    check("rst commit_state", commit_state, 2'b00);
    check("rst err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Valid held high with hits: one accept every two cycles.
    ncom = 0; last_addr = '0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_hit = 1'b1; state_in = MODIFIED; state_next = MODIFIED;
      bus_next = 2'b00; wbb = 1'b0; req_addr = 32'hB000 + c;
      @(negedge clk);
      if (commit_valid) begin ncom++; last_addr = commit_addr; end
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (commit_valid) begin ncom++; last_addr = commit_addr; end
    check("b2b commit_count", ncom, 4);
    check("b2b last_commit_addr", last_addr, 32'hB006);

    // Reset in the middle of a transfer: bus released at once, nothing committed.
    req_valid = 1'b1; req_hit = 1'b0; state_in = INVALID; state_next = SHARED;
    bus_next = BUS_READ_MISS; wbb = 1'b0; req_addr = 32'hA000;
    @(negedge clk);
    req_valid = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    check("rst_mid bus_req_before", bus_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid bus_req", bus_req, 1'b0);
    check("rst_mid req_ready", req_ready, 1'b1);
    check("rst_mid err", err, 1'b0);
    bus_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    err_sticky = 1'b0;
    ncom = 0;
    repeat (6) begin
      @(negedge clk);
      if (commit_valid) ncom++;
    end
    check("rst_mid no_commit", ncom, 0);

    for (int i = 0; i < 40; i++) begin
      v.hit = 1'($urandom);
      v.si  = 2'($urandom_range(0, 2));
      v.sn  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      v.bn  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      v.wb  = 1'($urandom);
      v.ra  = $urandom; v.wa = $urandom;
      v.wd  = {$urandom, $urandom, $urandom, $urandom};
      v.gd  = $urandom_range(0, 3);
      v.w0  = $urandom_range(0, 5);
      v.w1  = $urandom_range(0, 5);
      v = model(v, err_sticky);
      err_sticky = v.exp_err;
      run_req($sformatf("rand%0d", i), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
